// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection scheduler and its environment:
// timebase tick and requests in, right-of-way, lamps and countdown out.
interface intersection_phase_scheduler_if #(
  parameter int CW = 4
);
  logic          tick;
  logic [2:0]    req;
  logic [2:0]    grant;
  logic [2:0]    main_lights;
  logic [2:0]    side_lights;
  logic          ped_walk;
  logic [CW-1:0] remaining;

  modport master (
    output tick, req,
    input  grant, main_lights, side_lights, ped_walk, remaining
  );

  modport slave (
    input  tick, req,
    output grant, main_lights, side_lights, ped_walk, remaining
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Round-robin right-of-way scheduler for a main road, a side road and a
// pedestrian crossing, with min/max green, extension and recall to main.
module intersection_phase_scheduler #(
  parameter int T_MIN_GREEN = 5,
  parameter int T_MAX_GREEN = 15,
  parameter int T_AMBER     = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6,
  parameter int CW          = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  intersection_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_RESET_RED,
    S_GREEN,
    S_AMBER,
    S_PED_WALK,
    S_PED_FLASH,
    S_ALL_RED
  } state_t;

  localparam logic [CW-1:0] LAST_MIN    = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] LAST_MAX    = CW'(T_MAX_GREEN - 1);
  localparam logic [CW-1:0] LAST_AMBER  = CW'(T_AMBER - 1);
  localparam logic [CW-1:0] LAST_ALLRED = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] LAST_WALK   = CW'(T_WALK - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    pending, pending_n;
  logic [1:0]    rr_ptr, rr_n;
  logic [1:0]    served, served_n;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          found;
  logic [2:0]    served_oh, winner_oh, holder, win_clr;

  assign served_oh = 3'b001 << served;
  assign winner_oh = 3'b001 << winner;
  // Only the phase actually using the right-of-way masks its own request.
  assign holder    = (state == S_GREEN || state == S_PED_WALK) ? served_oh : '0;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = 2'((32'(rr_ptr) + k) % 3);
      if (!found && pending[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    served_n = served;
    rr_n     = rr_ptr;
    win_clr  = '0;
    case (state)
      S_RESET_RED, S_ALL_RED: begin
        if (bus.tick && cnt == LAST_ALLRED) begin
          state_n  = (winner == 2'd2) ? S_PED_WALK : S_GREEN;
          served_n = winner;
          rr_n     = winner;
          win_clr  = winner_oh;
        end
      end
      S_GREEN: begin
        if (bus.tick && cnt >= LAST_MIN
            && ((|(pending & ~served_oh)) || served == 2'd1)
            && (!bus.req[served] || cnt == LAST_MAX))
          state_n = S_AMBER;
      end
      S_AMBER:     if (bus.tick && cnt == LAST_AMBER) state_n = S_ALL_RED;
      S_PED_WALK:  if (bus.tick && cnt == LAST_WALK)  state_n = S_PED_FLASH;
      S_PED_FLASH: if (bus.tick && cnt == LAST_AMBER) state_n = S_ALL_RED;
      default:     state_n = S_RESET_RED;
    endcase

    pending_n = (pending | (bus.req & ~holder)) & ~win_clr;

    if (state_n != state)
      cnt_n = '0;
    else if (bus.tick && !(state == S_GREEN && cnt == LAST_MAX))
      cnt_n = cnt + 1'b1;
    else
      cnt_n = cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RESET_RED;
      cnt     <= '0;
      pending <= '0;
      rr_ptr  <= 2'd2;
      served  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      rr_ptr  <= rr_n;
      served  <= served_n;
    end
  end

  logic main_g, main_y, side_g, side_y;
  logic [CW-1:0] remaining_d;
  logic          ped_d;

  always_comb begin
    main_g      = (state == S_GREEN) && served == 2'd0;
    main_y      = (state == S_AMBER) && served == 2'd0;
    side_g      = (state == S_GREEN) && served == 2'd1;
    side_y      = (state == S_AMBER) && served == 2'd1;
    ped_d       = 1'b0;
    remaining_d = '0;
    case (state)
      S_RESET_RED, S_ALL_RED: remaining_d = CW'(T_ALLRED) - cnt;
      S_AMBER:                remaining_d = CW'(T_AMBER) - cnt;
      S_PED_WALK: begin
        remaining_d = CW'(T_WALK) - cnt;
        ped_d       = 1'b1;
      end
      S_PED_FLASH: begin
        remaining_d = CW'(T_AMBER) - cnt;
        ped_d       = ~cnt[0];
      end
      default:                remaining_d = '0;
    endcase
  end

  assign bus.grant       = (state == S_RESET_RED) ? '0 : served_oh;
  assign bus.main_lights = {main_g, main_y, !(main_g || main_y)};
  assign bus.side_lights = {side_g, side_y, !(side_g || side_y)};
  assign bus.ped_walk    = ped_d;
  assign bus.remaining   = remaining_d;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: a phase/elapsed-seconds reference model predicts every
// clock's outputs, a negedge monitor compares them against the scheduler.
module tb_intersection_phase_scheduler;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;

  intersection_phase_scheduler_if #(.CW(CW)) bus ();

  intersection_phase_scheduler #(
    .T_MIN_GREEN(5),
    .T_MAX_GREEN(15),
    .T_AMBER(3),
    .T_ALLRED(2),
    .T_WALK(6),
    .CW(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    grant;
    logic [2:0]    main_l;
    logic [2:0]    side_l;
    logic          ped;
    logic [CW-1:0] rem;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Phases: 0 power-up red, 1 road green, 2 road amber, 3 walk, 4 flash, 5 all red
  int dur [6] = '{2, 0, 3, 6, 3, 2};
  int m_phase, m_el, m_road, m_rr;
  bit [2:0] m_pend;
  bit started = 1'b0;

  function automatic exp_t model_outputs();
    exp_t e;
    e.grant  = (m_phase == 0) ? 3'b000 : 3'(1 << m_road);
    e.main_l = (m_road == 0 && m_phase == 1) ? 3'b100 :
               (m_road == 0 && m_phase == 2) ? 3'b010 : 3'b001;
    e.side_l = (m_road == 1 && m_phase == 1) ? 3'b100 :
               (m_road == 1 && m_phase == 2) ? 3'b010 : 3'b001;
    e.ped    = (m_phase == 3) ? 1'b1 : (m_phase == 4) ? ((m_el % 2) == 0) : 1'b0;
    e.rem    = (m_phase == 1) ? '0 : CW'(dur[m_phase] - m_el);
    return e;
  endfunction

  always @(posedge clk) begin
    bit [2:0] hold, newp, others;
    int nxt, w;
    if (!rst_n) begin
      m_phase = 0; m_el = 0; m_pend = '0; m_rr = 2; m_road = 0;
      started = 1'b1;
    end else if (started) begin
      hold = (m_phase == 1 || m_phase == 3) ? 3'(1 << m_road) : 3'b000;
      newp = m_pend | (bus.req & ~hold);
      nxt  = m_phase;
      if (bus.tick) begin
        case (m_phase)
          0, 5: if (m_el == dur[m_phase] - 1) begin
            w = 0;
            for (int k = 3; k >= 1; k--)
              if (m_pend[(m_rr + k) % 3]) w = (m_rr + k) % 3;
            newp[w] = 1'b0;
            m_rr    = w;
            m_road  = w;
            nxt     = (w == 2) ? 3 : 1;
          end
          1: begin
            others = m_pend;
            others[m_road] = 1'b0;
            if (m_el >= 4 && (others != 0 || m_road == 1) &&
                (!bus.req[m_road] || m_el >= 14)) nxt = 2;
          end
          2: if (m_el == 2) nxt = 5;
          3: if (m_el == 5) nxt = 4;
          4: if (m_el == 2) nxt = 5;
          default: nxt = 0;
        endcase
      end
      if (nxt != m_phase) begin
        m_phase = nxt;
        m_el    = 0;
      end else if (bus.tick) begin
        m_el++;
      end
      m_pend = newp;
    end
    if (started) sb_q.push_back(model_outputs());
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("grant",       32'(bus.grant),       32'(e.grant));
      chk("main_lights", 32'(bus.main_lights), 32'(e.main_l));
      chk("side_lights", 32'(bus.side_lights), 32'(e.side_l));
      chk("ped_walk",    32'(bus.ped_walk),    32'(e.ped));
      chk("remaining",   32'(bus.remaining),   32'(e.rem));
    end
  end

  task automatic step(input logic t, input logic [2:0] r);
    @(posedge clk);
    #2;
    bus.tick = t;
    bus.req  = r;
  endtask

  task automatic ticks(input int n, input int per, input logic [2:0] r);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < per; c++)
        step(c == per - 1, r);
  endtask

  task automatic run_until_main_green(input int limit);
    bit seen_off = 1'b0;
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      step((i % 4) == 3, 3'b000);
      if (bus.main_lights !== 3'b100) seen_off = 1'b1;
      else if (seen_off) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_main_green timeout got none expected entry within %0d clk", limit);
    end
  endtask

  task automatic run_until_walk(input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      step((i % 4) == 3, 3'b000);
      if (bus.ped_walk === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_ped_walk timeout got none expected walk within %0d clk", limit);
    end
  endtask

  initial begin
    logic [2:0] r;
    logic       t;
    rst_n    = 1'b0;
    bus.tick = 1'b0;
    bus.req  = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle: power-up red then main holds green.
    ticks(52, 4, 3'b000);
    // Side pulse while main is well past minimum green.
    step(1'b0, 3'b010);
    ticks(20, 4, 3'b000);
    // Side held: max-green cap, then re-served until released.
    ticks(40, 4, 3'b010);
    ticks(12, 4, 3'b000);
    // Simultaneous side and pedestrian with rr_ptr at main.
    step(1'b0, 3'b110);
    ticks(30, 4, 3'b000);
    // Pedestrian request early in main green waits for minimum green.
    step(1'b0, 3'b010);
    run_until_main_green(400);
    ticks(1, 4, 3'b000);
    step(1'b0, 3'b100);
    ticks(25, 4, 3'b000);
    // Reset in the middle of a walk phase drops queued requests.
    step(1'b0, 3'b111);
    run_until_walk(400);
    ticks(2, 4, 3'b000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    ticks(25, 4, 3'b000);
    // Random requests with irregular and back-to-back ticks.
    r = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) r = 3'($urandom_range(0, 7));
      step(t, r);
      if ($urandom_range(0, 999) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end
    step(1'b0, 3'b000);
    step(1'b0, 3'b000);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
